// File: rtl/flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : flags_unit
// Brief    : Condition-code register with masked ALU flag capture, conditional
//            jump resolution and a LIFO for interrupt flag save/restore.
// Revision : 1.0 - initial release
// ============================================================================
module flags_unit #(
  parameter int SAVE_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic                            zeroIn,
  input  logic                            carryIn,
  input  logic                            overFlowIn,
  input  logic                            negativeIn,
  input  logic [3:0]                      flagWriteMask,
  input  logic                            setCarry,
  input  logic                            clrCarry,
  input  logic                            condValid,
  input  logic [1:0]                      condSel,
  input  logic                            saveFlags,
  input  logic                            restoreFlags,
  input  logic                            stall,
  output logic [3:0]                      flags,
  output logic                            takeBranch,
  output logic [$clog2(SAVE_DEPTH+1)-1:0] stackCount,
  output logic                            stackError
);

  localparam int c_CNTW = $clog2(SAVE_DEPTH + 1);
  localparam int c_IDXW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

  logic [3:0]        r_flags;
  logic [c_CNTW-1:0] r_count;
  logic              r_error;
  logic [3:0]        r_stack [SAVE_DEPTH];

  logic [3:0]        w_rawFlags;
  logic [3:0]        w_nextFlags;
  logic [3:0]        w_popFlags;
  logic [1:0]        w_testBit;
  logic [c_CNTW-1:0] w_countM1;
  logic              w_take;
  logic              w_push;
  logic              w_pop;
  logic              w_stackFull;
  logic              w_stackEmpty;
  logic              w_pushOk;
  logic              w_popOk;
  logic              w_errorEvt;

  // Map the jump condition selector onto the {N,V,C,Z} bit positions.
  always_comb begin
    w_testBit = 2'd0;
    case (condSel)
      2'd0:    w_testBit = 2'd0;
      2'd1:    w_testBit = 2'd3;
      2'd2:    w_testBit = 2'd1;
      default: w_testBit = 2'd2;
    endcase
  end

  assign w_take       = condValid & ~stall & r_flags[w_testBit];
  assign w_push       = saveFlags & ~restoreFlags;
  assign w_pop        = restoreFlags & ~saveFlags;
  assign w_stackFull  = (r_count == c_CNTW'(SAVE_DEPTH));
  assign w_stackEmpty = (r_count == '0);
  assign w_pushOk     = w_push & ~w_stackFull;
  assign w_popOk      = w_pop & ~w_stackEmpty;
  assign w_errorEvt   = (w_push & w_stackFull) | (w_pop & w_stackEmpty);
  assign w_countM1    = r_count - c_CNTW'(1);
  assign w_popFlags   = r_stack[w_countM1[c_IDXW-1:0]];
  assign w_rawFlags   = {negativeIn, overFlowIn, carryIn, zeroIn};

  // Later steps override earlier ones: mask, carry force, branch clear, pop.
  always_comb begin
    w_nextFlags = (flagWriteMask & w_rawFlags) | (~flagWriteMask & r_flags);
    if (clrCarry) begin
      w_nextFlags[1] = 1'b0;
    end else if (setCarry) begin
      w_nextFlags[1] = 1'b1;
    end
    if (w_take) begin
      w_nextFlags[w_testBit] = 1'b0;
    end
    if (w_popOk) begin
      w_nextFlags = w_popFlags;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_flags <= 4'b0000;
      r_count <= '0;
      r_error <= 1'b0;
    end else if (!stall) begin
      r_flags <= w_nextFlags;
      if (w_pushOk) begin
        r_count <= r_count + c_CNTW'(1);
      end else if (w_popOk) begin
        r_count <= w_countM1;
      end
      if (w_errorEvt) begin
        r_error <= 1'b1;
      end
    end
  end

  // Snapshot storage needs no reset; the count alone defines valid entries.
  always_ff @(posedge clk) begin
    if (!stall && w_pushOk) begin
      r_stack[r_count[c_IDXW-1:0]] <= r_flags;
    end
  end

  assign flags      = r_flags;
  assign takeBranch = w_take;
  assign stackCount = r_count;
  assign stackError = r_error;

endmodule
`default_nettype wire

// File: tb/tb_flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flags_unit
// Brief    : Self-checking bench for flags_unit against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flags_unit;

  localparam int SAVE_DEPTH = 4;
  localparam int CW = $clog2(SAVE_DEPTH + 1);

  logic          clk;
  logic          rstN;
  logic          zeroIn, carryIn, overFlowIn, negativeIn;
  logic [3:0]    flagWriteMask;
  logic          setCarry, clrCarry;
  logic          condValid;
  logic [1:0]    condSel;
  logic          saveFlags, restoreFlags, stall;
  logic [3:0]    flags;
  logic          takeBranch;
  logic [CW-1:0] stackCount;
  logic          stackError;

  int nTests = 0;
  int nFail  = 0;

  logic [3:0] mFlags;
  logic [3:0] mStack [$];
  logic       mErr;
  int         selMap [4] = '{0, 3, 1, 2};

  flags_unit #(.SAVE_DEPTH(SAVE_DEPTH)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .zeroIn       (zeroIn),
    .carryIn      (carryIn),
    .overFlowIn   (overFlowIn),
    .negativeIn   (negativeIn),
    .flagWriteMask(flagWriteMask),
    .setCarry     (setCarry),
    .clrCarry     (clrCarry),
    .condValid    (condValid),
    .condSel      (condSel),
    .saveFlags    (saveFlags),
    .restoreFlags (restoreFlags),
    .stall        (stall),
    .flags        (flags),
    .takeBranch   (takeBranch),
    .stackCount   (stackCount),
    .stackError   (stackError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: tests=%0d failed=%0d", nTests, nFail);
    $fatal(1, "bench did not finish");
  end

  task automatic clearIn();
    zeroIn = 0; carryIn = 0; overFlowIn = 0; negativeIn = 0;
    flagWriteMask = 4'b0000; setCarry = 0; clrCarry = 0;
    condValid = 0; condSel = 2'd0; saveFlags = 0; restoreFlags = 0; stall = 0;
  endtask

  task automatic modelReset();
    mFlags = 4'b0000;
    mStack.delete();
    mErr = 1'b0;
  endtask

  function automatic logic expTake();
    return condValid && !stall && mFlags[selMap[condSel]];
  endfunction

  // One clock: inputs were driven at the previous falling edge.
  task automatic cycle();
    logic [3:0] nf;
    logic [3:0] inV;
    logic       tk;
    tk = expTake();
    @(posedge clk);
    if (rstN && !stall) begin
      nf  = mFlags;
      inV = {negativeIn, overFlowIn, carryIn, zeroIn};
      for (int b = 0; b < 4; b++) if (flagWriteMask[b]) nf[b] = inV[b];
      if (clrCarry) nf[1] = 1'b0;
      else if (setCarry) nf[1] = 1'b1;
      if (tk) nf[selMap[condSel]] = 1'b0;
      if (saveFlags && !restoreFlags) begin
        if (mStack.size() < SAVE_DEPTH) mStack.push_back(mFlags);
        else mErr = 1'b1;
      end else if (restoreFlags && !saveFlags) begin
        if (mStack.size() > 0) nf = mStack.pop_back();
        else mErr = 1'b1;
      end
      mFlags = nf;
    end
    @(negedge clk);
  endtask

  task automatic setFlagsTo(input logic [3:0] v);
    clearIn();
    flagWriteMask = 4'b1111;
    {negativeIn, overFlowIn, carryIn, zeroIn} = v;
    cycle();
    clearIn();
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    clearIn();
    @(negedge clk);
    @(negedge clk);
    modelReset();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    nTests++;
    if (flags !== 4'b0000) begin nFail++; $display("FAIL reset_flags got %b expected %b", flags, 4'b0000); end
    nTests++;
    if (stackCount !== CW'(0)) begin nFail++; $display("FAIL reset_count got %0d expected 0", stackCount); end
    nTests++;
    if (stackError !== 1'b0) begin nFail++; $display("FAIL reset_error got %b expected 0", stackError); end
  endtask

  task automatic test_write_mask();
    clearIn();
    flagWriteMask = 4'b1111;
    negativeIn = 1; overFlowIn = 0; carryIn = 1; zeroIn = 0;
    cycle();
    nTests++;
    if (flags !== 4'b1010) begin nFail++; $display("FAIL mask_all got %b expected %b", flags, 4'b1010); end
    clearIn();
    flagWriteMask = 4'b0001;
    zeroIn = 1;
    cycle();
    nTests++;
    if (flags !== 4'b1011) begin nFail++; $display("FAIL mask_z got %b expected %b", flags, 4'b1011); end
    clearIn();
  endtask

  task automatic test_branch();
    setFlagsTo(4'b0001);
    condValid = 1; condSel = 2'd0;
    #1;
    nTests++;
    if (takeBranch !== 1'b1) begin nFail++; $display("FAIL branch_z_take got %b expected 1", takeBranch); end
    cycle();
    nTests++;
    if (flags !== 4'b0000) begin nFail++; $display("FAIL branch_z_clear got %b expected %b", flags, 4'b0000); end
    setFlagsTo(4'b0001);
    condValid = 1; condSel = 2'd2;
    #1;
    nTests++;
    if (takeBranch !== 1'b0) begin nFail++; $display("FAIL branch_c_take got %b expected 0", takeBranch); end
    cycle();
    nTests++;
    if (flags !== 4'b0001) begin nFail++; $display("FAIL branch_c_hold got %b expected %b", flags, 4'b0001); end
    setFlagsTo(4'b1000);
    condValid = 1; condSel = 2'd1;
    #1;
    nTests++;
    if (takeBranch !== 1'b1) begin nFail++; $display("FAIL branch_n_take got %b expected 1", takeBranch); end
    cycle();
    clearIn();
  endtask

  task automatic test_carry();
    setFlagsTo(4'b0000);
    flagWriteMask = 4'b0010; carryIn = 1; setCarry = 1; clrCarry = 1;
    cycle();
    nTests++;
    if (flags[1] !== 1'b0) begin nFail++; $display("FAIL carry_clr_wins got %b expected 0", flags[1]); end
    clearIn();
    setCarry = 1;
    cycle();
    nTests++;
    if (flags[1] !== 1'b1) begin nFail++; $display("FAIL carry_set got %b expected 1", flags[1]); end
    clearIn();
  endtask

  task automatic test_stack();
    doReset();
    for (int v = 1; v <= 4; v++) begin
      setFlagsTo(4'(v));
      saveFlags = 1;
      cycle();
      clearIn();
    end
    nTests++;
    if (stackCount !== CW'(4)) begin nFail++; $display("FAIL stack_full_count got %0d expected 4", stackCount); end
    nTests++;
    if (stackError !== 1'b0) begin nFail++; $display("FAIL stack_full_noerr got %b expected 0", stackError); end
    saveFlags = 1;
    cycle();
    clearIn();
    nTests++;
    if (stackCount !== CW'(4)) begin nFail++; $display("FAIL overflow_count got %0d expected 4", stackCount); end
    nTests++;
    if (stackError !== 1'b1) begin nFail++; $display("FAIL overflow_err got %b expected 1", stackError); end
    for (int i = 0; i < 4; i++) begin
      restoreFlags = 1;
      cycle();
      clearIn();
      nTests++;
      if (flags !== 4'(4 - i)) begin nFail++; $display("FAIL restore%0d_flags got %b expected %b", i, flags, 4'(4 - i)); end
      nTests++;
      if (stackCount !== CW'(3 - i)) begin nFail++; $display("FAIL restore%0d_count got %0d expected %0d", i, stackCount, 3 - i); end
    end
    restoreFlags = 1;
    cycle();
    clearIn();
    nTests++;
    if (flags !== 4'b0001) begin nFail++; $display("FAIL underflow_flags got %b expected %b", flags, 4'b0001); end
    nTests++;
    if (stackCount !== CW'(0)) begin nFail++; $display("FAIL underflow_count got %0d expected 0", stackCount); end
  endtask

  task automatic test_priority_stall();
    doReset();
    setFlagsTo(4'b0101);
    saveFlags = 1;
    cycle();
    setFlagsTo(4'b0000);
    restoreFlags = 1; flagWriteMask = 4'b1111;
    {negativeIn, overFlowIn, carryIn, zeroIn} = 4'b1111;
    cycle();
    clearIn();
    nTests++;
    if (flags !== 4'b0101) begin nFail++; $display("FAIL pop_wins got %b expected %b", flags, 4'b0101); end
    saveFlags = 1;
    cycle();
    clearIn();
    stall = 1; saveFlags = 1; flagWriteMask = 4'b1111;
    {negativeIn, overFlowIn, carryIn, zeroIn} = 4'b1010;
    condValid = 1; condSel = 2'd0;
    #1;
    nTests++;
    if (takeBranch !== 1'b0) begin nFail++; $display("FAIL stall_take got %b expected 0", takeBranch); end
    cycle();
    clearIn();
    nTests++;
    if (flags !== 4'b0101) begin nFail++; $display("FAIL stall_flags got %b expected %b", flags, 4'b0101); end
    nTests++;
    if (stackCount !== CW'(1)) begin nFail++; $display("FAIL stall_count got %0d expected 1", stackCount); end
  endtask

  task automatic test_async_reset();
    doReset();
    restoreFlags = 1;
    cycle();
    clearIn();
    setFlagsTo(4'b1111);
    saveFlags = 1;
    cycle();
    cycle();
    clearIn();
    nTests++;
    if (stackCount !== CW'(2) || stackError !== 1'b1) begin
      nFail++; $display("FAIL async_pre got count=%0d err=%b expected count=2 err=1", stackCount, stackError);
    end
    #2 rstN = 1'b0;
    #1;
    nTests++;
    if (flags !== 4'b0000) begin nFail++; $display("FAIL async_flags got %b expected 0000", flags); end
    nTests++;
    if (stackCount !== CW'(0)) begin nFail++; $display("FAIL async_count got %0d expected 0", stackCount); end
    nTests++;
    if (stackError !== 1'b0) begin nFail++; $display("FAIL async_err got %b expected 0", stackError); end
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_random();
    doReset();
    for (int n = 0; n < 400; n++) begin
      condValid     = 1'($urandom % 2);
      condSel       = 2'($urandom % 4);
      flagWriteMask = 4'($urandom % 16);
      {negativeIn, overFlowIn, carryIn, zeroIn} = 4'($urandom % 16);
      setCarry      = ($urandom % 4) == 0;
      clrCarry      = ($urandom % 4) == 0;
      saveFlags     = ($urandom % 3) == 0;
      restoreFlags  = ($urandom % 3) == 0;
      stall         = ($urandom % 8) == 0;
      #1;
      nTests++;
      if (takeBranch !== expTake()) begin
        nFail++; $display("FAIL rnd%0d_take got %b expected %b", n, takeBranch, expTake());
      end
      cycle();
      nTests++;
      if (flags !== mFlags || stackCount !== CW'(mStack.size()) || stackError !== mErr) begin
        nFail++;
        $display("FAIL rnd%0d_state got flags=%b count=%0d err=%b expected flags=%b count=%0d err=%b",
                 n, flags, stackCount, stackError, mFlags, mStack.size(), mErr);
      end
    end
    clearIn();
  endtask

  initial begin
    rstN = 1'b0;
    clearIn();
    modelReset();
    test_reset();
    test_write_mask();
    test_branch();
    test_carry();
    test_stack();
    test_priority_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
